// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: a pixel-rate strobe, free-running x/y counters
// and registered sync/blank/frame-start decodes that line up with x/y.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic       clk,
  input  logic       reset,
  output logic       pix_en,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       hsync,
  output logic       vsync,
  output logic       blank_n,
  output logic       frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             pix_en_q, pix_en_d;
  logic [9:0]       x_q, x_d;
  logic [9:0]       y_q, y_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             blank_n_q, blank_n_d;
  logic             frame_start_q, frame_start_d;

  always_comb begin
    div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DIV_W'(1);
    pix_en_d  = (div_cnt_q == DIV_LAST);

    x_d = x_q;
    y_d = y_q;
    if (pix_en_q) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
    end

    // Decodes use the next x/y so the registered outputs match x/y cycle for cycle.
    hsync_d       = !((x_d >= HS_START) && (x_d < HS_END));
    vsync_d       = !((y_d >= VS_START) && (y_d < VS_END));
    blank_n_d     = (x_d < H_VIS) && (y_d < V_VIS);
    frame_start_d = pix_en_q && (x_q == X_LAST) && (y_q == Y_LAST);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt_q     <= '0;
      pix_en_q      <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      blank_n_q     <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      pix_en_q      <= pix_en_d;
      x_q           <= x_d;
      y_q           <= y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      blank_n_q     <= blank_n_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pix_en      = pix_en_q;
  assign x           = x_q;
  assign y           = y_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign blank_n     = blank_n_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: one default-geometry instance (CLK_DIV=2) and one small-geometry
// instance (CLK_DIV=1) so frame wraps and vertical timing fit in a short run.
module tb_vga_timing_gen;

  typedef struct packed {
    logic       pe;
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       bn;
    logic       fs;
  } vout_t;

  typedef struct {
    int    phase;
    int    e;
    vout_t ea;
    vout_t eb;
  } item_t;

  typedef struct {
    int dut;
    int e;
    int x;
    int y;
    bit hs;
    bit vs;
    bit bn;
    bit fs;
  } dir_t;

  logic clk;
  logic reset;
  logic       a_pe, a_hs, a_vs, a_bn, a_fs;
  logic [9:0] a_x, a_y;
  logic       b_pe, b_hs, b_vs, b_bn, b_fs;
  logic [9:0] b_x, b_y;
  vout_t      a_act, b_act;

  item_t sb[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  bit    stim_done = 1'b0;

  // Hand-computed points: default instance on line 0/1, small instance at vsync and frame wrap.
  dir_t dtab[14] = '{
    '{0,    3,   1, 0, 1'b1, 1'b1, 1'b1, 1'b0},
    '{0, 1279, 639, 0, 1'b1, 1'b1, 1'b1, 1'b0},
    '{0, 1281, 640, 0, 1'b1, 1'b1, 1'b0, 1'b0},
    '{0, 1311, 655, 0, 1'b1, 1'b1, 1'b0, 1'b0},
    '{0, 1313, 656, 0, 1'b0, 1'b1, 1'b0, 1'b0},
    '{0, 1503, 751, 0, 1'b0, 1'b1, 1'b0, 1'b0},
    '{0, 1505, 752, 0, 1'b1, 1'b1, 1'b0, 1'b0},
    '{0, 1599, 799, 0, 1'b1, 1'b1, 1'b0, 1'b0},
    '{0, 1601,   0, 1, 1'b1, 1'b1, 1'b1, 1'b0},
    '{1,  301,   0, 10, 1'b1, 1'b0, 1'b0, 1'b0},
    '{1,  361,   0, 12, 1'b1, 1'b1, 1'b0, 1'b0},
    '{1,  450,  29, 14, 1'b1, 1'b1, 1'b0, 1'b0},
    '{1,  451,   0, 0, 1'b1, 1'b1, 1'b1, 1'b1},
    '{1,  452,   1, 0, 1'b1, 1'b1, 1'b1, 1'b0}
  };

  vga_timing_gen #(.CLK_DIV(2)) u_dut_a (
    .clk(clk), .reset(reset), .pix_en(a_pe), .x(a_x), .y(a_y),
    .hsync(a_hs), .vsync(a_vs), .blank_n(a_bn), .frame_start(a_fs)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
    .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) u_dut_b (
    .clk(clk), .reset(reset), .pix_en(b_pe), .x(b_x), .y(b_y),
    .hsync(b_hs), .vsync(b_vs), .blank_n(b_bn), .frame_start(b_fs)
  );

  assign a_act = {a_pe, a_x, a_y, a_hs, a_vs, a_bn, a_fs};
  assign b_act = {b_pe, b_x, b_y, b_hs, b_vs, b_bn, b_fs};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs after the e-th clock edge since reset release (e=0: in reset).
  function automatic vout_t model(int e, int d, int ha, int hfp, int hsw, int hbp,
                                  int va, int vfp, int vsw, int vbp);
    vout_t v;
    int ht, vt, n, xi, yi;
    bit adv;
    ht = ha + hfp + hsw + hbp;
    vt = va + vfp + vsw + vbp;
    if (e == 0) begin
      v = '0;
      v.hs = 1'b1;
      v.vs = 1'b1;
      v.bn = 1'b1;
      return v;
    end
    n   = (e - 1) / d;
    xi  = n % ht;
    yi  = (n / ht) % vt;
    adv = ((e - 1) % d == 0) && (e >= 2);
    v.pe = (e % d == 0);
    v.x  = 10'(xi);
    v.y  = 10'(yi);
    v.hs = !((xi >= ha + hfp) && (xi < ha + hfp + hsw));
    v.vs = !((yi >= va + vfp) && (yi < va + vfp + vsw));
    v.bn = (xi < ha) && (yi < va);
    v.fs = adv && (n > 0) && (n % (ht * vt) == 0);
    return v;
  endfunction

  function automatic string vstr(vout_t v);
    return $sformatf("pe=%0d x=%0d y=%0d hs=%0d vs=%0d bn=%0d fs=%0d",
                     v.pe, v.x, v.y, v.hs, v.vs, v.bn, v.fs);
  endfunction

  task automatic push(input int phase, input int e);
    item_t it;
    it.phase = phase;
    it.e     = e;
    it.ea    = model(e, 2, 640, 16, 96, 48, 480, 10, 2, 33);
    it.eb    = model(e, 1, 16, 4, 6, 4, 8, 2, 2, 3);
    sb.push_back(it);
  endtask

  // Stimulus: reset, long run, asynchronous reset mid-line/mid-frame, second run.
  initial begin
    reset = 1'b0;
    repeat (5) begin @(posedge clk); #1; push(0, 0); end
    reset = 1'b1;
    for (int e = 1; e <= 3801; e++) begin @(posedge clk); #1; push(1, e); end
    @(posedge clk); #1;
    reset = 1'b0;
    push(2, 0);
    repeat (4) begin @(posedge clk); #1; push(2, 0); end
    reset = 1'b1;
    for (int e = 1; e <= 1000; e++) begin @(posedge clk); #1; push(3, e); end
    stim_done = 1'b1;
  end

  // Monitor: pops one expectation per cycle and compares, away from the rising edge.
  initial begin
    item_t it;
    vout_t act;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        it = sb.pop_front();
        n_checks++;
        if (a_act !== it.ea) begin
          n_fail++;
          $display("FAIL dutA phase=%0d e=%0d act: %s exp: %s", it.phase, it.e, vstr(a_act), vstr(it.ea));
        end
        n_checks++;
        if (b_act !== it.eb) begin
          n_fail++;
          $display("FAIL dutB phase=%0d e=%0d act: %s exp: %s", it.phase, it.e, vstr(b_act), vstr(it.eb));
        end
        if (it.phase == 1) begin
          foreach (dtab[i]) begin
            if (dtab[i].e == it.e) begin
              act = (dtab[i].dut == 1) ? b_act : a_act;
              n_checks++;
              if (act.x !== 10'(dtab[i].x) || act.y !== 10'(dtab[i].y) ||
                  act.hs !== dtab[i].hs || act.vs !== dtab[i].vs ||
                  act.bn !== dtab[i].bn || act.fs !== dtab[i].fs) begin
                n_fail++;
                $display("FAIL directed dut=%0d e=%0d act: %s exp: x=%0d y=%0d hs=%0d vs=%0d bn=%0d fs=%0d",
                         dtab[i].dut, it.e, vstr(act), dtab[i].x, dtab[i].y,
                         dtab[i].hs, dtab[i].vs, dtab[i].bn, dtab[i].fs);
              end
            end
          end
        end
      end else if (stim_done) begin
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete within time limit, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
